// File: rtl/control_unit.sv
// control_unit: five-state fetch/execute sequencer decoding a 16-bit instruction into datapath controls.
module control_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  SeqState
);
    typedef enum logic [2:0] {
        FETCH_L = 3'b000,
        FETCH_H = 3'b001,
        EXEC1   = 3'b010,
        EXEC2   = 3'b011,
        HALT    = 3'b100
    } state_t;

    state_t state_q, state_d;

    logic [3:0] opcode;
    logic [1:0] rx, ry;
    logic [3:0] rx_onehot;

    assign opcode    = IROut[15:12];
    assign rx        = IROut[11:10];
    assign ry        = IROut[9:8];
    assign rx_onehot = 4'b1000 >> rx;
    assign SeqState  = state_q;

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= FETCH_L;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 2'b00;
        RF_RSel     = 4'b0000;
        RF_TSel     = 4'b0000;
        ALU_FunSel  = 4'b0000;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 4'b0000;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'b00;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        // Reset overrides every state so no partial write can slip through.
        if (Reset) begin
            ARF_RegSel = 4'b1110;
            RF_RSel    = 4'b1111;
        end else begin
            case (state_q)
                FETCH_L, FETCH_H: begin
                    Mem_CS     = 1'b0;
                    IR_Enable  = 1'b1;
                    IR_LH      = (state_q == FETCH_H);
                    IR_Funsel  = 2'b01;
                    ARF_RegSel = 4'b1000;
                    ARF_FunSel = 2'b10;
                    state_d    = (state_q == FETCH_L) ? FETCH_H : EXEC1;
                end
                EXEC1: begin
                    state_d = FETCH_L;
                    case (opcode)
                        4'h0: begin
                            MuxASel   = 2'b10;
                            RF_FunSel = 2'b01;
                            RF_RSel   = rx_onehot;
                        end
                        4'h1, 4'h2: begin
                            MuxBSel    = 2'b10;
                            ARF_RegSel = 4'b0100;
                            ARF_FunSel = 2'b01;
                            state_d    = EXEC2;
                        end
                        4'h3: begin
                            RF_OutASel = {1'b0, rx};
                            RF_OutBSel = {1'b0, ry};
                            ALU_FunSel = 4'b0100;
                            RF_FunSel  = 2'b01;
                            RF_RSel    = rx_onehot;
                        end
                        4'h4: begin
                            RF_FunSel = 2'b10;
                            RF_RSel   = rx_onehot;
                        end
                        4'h5, 4'h6: begin
                            if (opcode == 4'h5 || ALUOutFlag[3]) begin
                                MuxBSel    = 2'b10;
                                ARF_RegSel = 4'b1000;
                                ARF_FunSel = 2'b01;
                            end
                        end
                        4'hF: state_d = HALT;
                        default: ;
                    endcase
                end
                EXEC2: begin
                    state_d = FETCH_L;
                    if (opcode == 4'h1) begin
                        ARF_OutDSel = 2'b01;
                        Mem_CS      = 1'b0;
                        MuxASel     = 2'b01;
                        RF_FunSel   = 2'b01;
                        RF_RSel     = rx_onehot;
                    end else if (opcode == 4'h2) begin
                        ARF_OutDSel = 2'b01;
                        RF_OutASel  = {1'b0, rx};
                        Mem_CS      = 1'b0;
                        Mem_WR      = 1'b1;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = FETCH_L;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for the control_unit sequencer.
module tb_control_unit;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel, SeqState;
    logic [1:0]  RF_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, IR_Funsel, MuxASel, MuxBSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel;

    int n_checks = 0;
    int n_fail   = 0;
    int rule_viol = 0;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .SeqState(SeqState)
    );

    always #5 Clock = ~Clock;

    // Write only with chip select in STM EXEC2; one-hot enables outside reset.
    always @(negedge Clock) begin
        if (Mem_WR && (Mem_CS || SeqState != 3'b011)) rule_viol++;
        if (!Reset && ($countones(RF_RSel) > 1 || $countones(ARF_RegSel) > 1)) rule_viol++;
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic to_exec1(input logic [15:0] ir);
        IROut = ir;
        step();
        step();
        check("at_exec1", 16'(SeqState), 16'h2);
    endtask

    initial begin
        Reset = 1'b1;
        IROut = 16'h0000;
        ALUOutFlag = 4'b0000;
        #1;
        check("rst_arf_regsel", 16'(ARF_RegSel), 16'hE);
        check("rst_rf_rsel", 16'(RF_RSel), 16'hF);
        check("rst_rf_fun", 16'(RF_FunSel), 16'h0);
        check("rst_arf_fun", 16'(ARF_FunSel), 16'h0);
        check("rst_mem_cs", 16'(Mem_CS), 16'h1);
        check("rst_ir_en", 16'(IR_Enable), 16'h0);
        step();
        step();
        check("rst_state", 16'(SeqState), 16'h0);
        Reset = 1'b0;
        #1;
        check("fl_cs", 16'(Mem_CS), 16'h0);
        check("fl_ir_en", 16'(IR_Enable), 16'h1);
        check("fl_lh", 16'(IR_LH), 16'h0);
        check("fl_irfun", 16'(IR_Funsel), 16'h1);
        check("fl_pc_inc", {8'h0, ARF_RegSel, 2'b0, ARF_FunSel}, 16'h0082);
        IROut = 16'h0C5A;
        step();
        check("fh_state", 16'(SeqState), 16'h1);
        check("fh_cs", 16'(Mem_CS), 16'h0);
        check("fh_ir_en", 16'(IR_Enable), 16'h1);
        check("fh_lh", 16'(IR_LH), 16'h1);
        step();
        check("ldi_state", 16'(SeqState), 16'h2);
        check("ldi_muxa", 16'(MuxASel), 16'h2);
        check("ldi_rsel", 16'(RF_RSel), 16'h1);
        check("ldi_fun", 16'(RF_FunSel), 16'h1);
        step();
        check("ldi_next", 16'(SeqState), 16'h0);

        to_exec1(16'h2440);
        check("stm1_arf", 16'(ARF_RegSel), 16'h4);
        check("stm1_muxb", 16'(MuxBSel), 16'h2);
        check("stm1_arffun", 16'(ARF_FunSel), 16'h1);
        check("stm1_wr", 16'(Mem_WR), 16'h0);
        step();
        check("stm2_state", 16'(SeqState), 16'h3);
        check("stm2_dsel", 16'(ARF_OutDSel), 16'h1);
        check("stm2_asel", 16'(RF_OutASel), 16'h1);
        check("stm2_wr_cs", {Mem_WR, Mem_CS, MuxCSel, ALU_FunSel}, 16'h40);
        check("stm2_rsel", 16'(RF_RSel), 16'h0);
        step();
        check("stm_next", 16'(SeqState), 16'h0);

        to_exec1(16'h1840);
        step();
        check("ldm2_state", 16'(SeqState), 16'h3);
        check("ldm2_load", {RF_RSel, 2'b0, RF_FunSel, 2'b0, MuxASel, 2'b0, ARF_OutDSel}, 16'h2111);
        check("ldm2_cs_wr", {Mem_CS, Mem_WR}, 16'h0);
        step();

        to_exec1(16'h3600);
        check("add_ab", {RF_OutASel, 1'b0, RF_OutBSel}, 16'h12);
        check("add_alu", {ALU_FunSel, MuxASel, RF_FunSel}, 16'h41);
        check("add_rsel", 16'(RF_RSel), 16'h4);
        step();

        to_exec1(16'h4000);
        check("inc", {RF_RSel, 2'b0, RF_FunSel}, 16'h82);
        step();

        to_exec1(16'h5012);
        check("bra", {ARF_RegSel, 2'b0, MuxBSel, 2'b0, ARF_FunSel}, 16'h821);
        step();

        ALUOutFlag = 4'b1000;
        to_exec1(16'h6020);
        check("beq_taken", {ARF_RegSel, 2'b0, MuxBSel, 2'b0, ARF_FunSel}, 16'h821);
        ALUOutFlag = 4'b0000;
        #1;
        check("beq_not_taken", {ARF_RegSel, 2'b0, MuxBSel}, 16'h0);
        step();
        check("beq_next", 16'(SeqState), 16'h0);

        to_exec1(16'h7000);
        check("nop_idle", {RF_RSel, ARF_RegSel, 3'b0, Mem_CS, 3'b0, IR_Enable}, 16'h0010);
        step();

        to_exec1(16'h2440);
        Reset = 1'b1;
        #1;
        check("mid_rst_wr", 16'(Mem_WR), 16'h0);
        step();
        check("mid_rst_state", 16'(SeqState), 16'h0);
        check("mid_rst_wr2", 16'(Mem_WR), 16'h0);
        Reset = 1'b0;
        #1;

        to_exec1(16'hF000);
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_state", 16'(SeqState), 16'h4);
            check("halt_cs", 16'(Mem_CS), 16'h1);
        end
        Reset = 1'b1;
        step();
        check("halt_rst", 16'(SeqState), 16'h0);
        Reset = 1'b0;
        step();
        check("rule_viol", 16'(rule_viol), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
